// File: rtl/sr_updown_counter_n.sv
// sr_updown_counter_n: parametrised up/down counter with programmable modulus,
// synchronous parallel load, wrap/saturate selection and a sticky range flag.
// A raw step_in level is synchronised and edge-detected on clk.
// Count storage is modelled as per-bit SR cells driven from a next-state vector.
module sr_updown_counter_n #(
  parameter int WIDTH       = 8,
  parameter int MODULUS     = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_in,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             sat_mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             step_pulse
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  // Warm-up shift register: becomes all ones SYNC_STAGES+1 edges after reset.
  // Until then the history flop has not absorbed a real synchronised sample,
  // so a level already high at reset release must not look like a rising edge.
  logic [SYNC_STAGES:0]   vld_q, vld_d;
  logic                   hist_q, hist_d;
  logic                   step_pulse_q, step_pulse_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;

  logic                   step;
  logic                   ovf_evt;
  logic [WIDTH-1:0]       next_cnt;
  logic [WIDTH-1:0]       set_bits;
  logic [WIDTH-1:0]       rst_bits;

  // Synchroniser shift, edge-detect history and warm-up tracking.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], step_in};
    hist_d       = sync_q[SYNC_STAGES-1];
    vld_d        = {vld_q[SYNC_STAGES-1:0], 1'b1};
    step         = sync_q[SYNC_STAGES-1] & ~hist_q & vld_q[SYNC_STAGES];
    step_pulse_d = step;
  end

  // Next count: load beats step beats hold; range ends wrap or saturate.
  always_comb begin
    next_cnt = count_q;
    ovf_evt  = 1'b0;
    if (load) begin
      if (d > MAX_VAL) begin
        next_cnt = MAX_VAL;
        ovf_evt  = 1'b1;
      end else begin
        next_cnt = d;
      end
    end else if (step) begin
      if (up) begin
        if (count_q == MAX_VAL) begin
          ovf_evt  = 1'b1;
          next_cnt = sat_mode ? count_q : '0;
        end else begin
          next_cnt = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          ovf_evt  = 1'b1;
          next_cnt = sat_mode ? count_q : MAX_VAL;
        end else begin
          next_cnt = count_q - 1'b1;
        end
      end
    end
    // A set event on the same edge as a clear keeps the flag high.
    ovf_d = ovf_evt | (ovf_q & ~clr_ovf);
  end

  // Per-bit SR cells: set drives a 0 bit to 1, reset drives a 1 bit to 0.
  assign set_bits = next_cnt & ~count_q;
  assign rst_bits = ~next_cnt & count_q;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sr_cell
      assign count_d[gi] = set_bits[gi] ? 1'b1 :
                           rst_bits[gi] ? 1'b0 : count_q[gi];
    end
  endgenerate

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      vld_q        <= '0;
      hist_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      vld_q        <= vld_d;
      hist_q       <= hist_d;
      step_pulse_q <= step_pulse_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
    end
  end

  assign q          = count_q;
  assign ovf        = ovf_q;
  assign step_pulse = step_pulse_q;
  assign tc         = (up && (count_q == MAX_VAL)) || (!up && (count_q == '0));

  // Invariants of the counter.
  a_range : assert property (@(posedge clk) disable iff (!rst_n) count_q <= MAX_VAL);
  a_sr    : assert property (@(posedge clk) disable iff (!rst_n) (set_bits & rst_bits) == '0);
  a_pulse : assert property (@(posedge clk) disable iff (!rst_n) step_pulse_q |=> !step_pulse_q);
  a_nox   : assert property (@(posedge clk) disable iff (!rst_n)
                             !$isunknown({count_q, tc, ovf_q, step_pulse_q}));

endmodule
